// File: rtl/rf_pkg.sv
// ============================================================================
//  Module  : rf_pkg
//  Brief   : Shared encodings and sizing constants for the register file.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  typedef enum logic [1:0] {
    FUN_DEC  = 2'b00,
    FUN_INC  = 2'b01,
    FUN_LOAD = 2'b10,
    FUN_CLR  = 2'b11
  } fun_sel_e;

  localparam logic [2:0] SEL_R1 = 3'd0;
  localparam logic [2:0] SEL_R2 = 3'd1;
  localparam logic [2:0] SEL_R3 = 3'd2;
  localparam logic [2:0] SEL_R4 = 3'd3;
  localparam logic [2:0] SEL_S1 = 3'd4;
  localparam logic [2:0] SEL_S2 = 3'd5;
  localparam logic [2:0] SEL_S3 = 3'd6;
  localparam logic [2:0] SEL_S4 = 3'd7;

  localparam int NUM_GP  = 4;
  localparam int NUM_SCR = 4;
  localparam int NUM_REG = NUM_GP + NUM_SCR;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/reg16_cell.sv
// ============================================================================
//  Module  : reg16_cell
//  Brief   : One register with dec/inc/load/clear; RF_SAT_EN makes inc/dec saturate.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reg16_cell
  import rf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_nxt;

`ifdef RF_SAT_EN
  assign w_inc = (r_q == {WIDTH{1'b1}}) ? r_q : r_q + c_one;
  assign w_dec = (r_q == {WIDTH{1'b0}}) ? r_q : r_q - c_one;
`else
  assign w_inc = r_q + c_one;
  assign w_dec = r_q - c_one;
`endif

  always_comb begin
    w_nxt = r_q;
    case (FunSel)
      FUN_DEC:  w_nxt = w_dec;
      FUN_INC:  w_nxt = w_inc;
      FUN_LOAD: w_nxt = I;
      FUN_CLR:  w_nxt = '0;
      default:  w_nxt = r_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q <= '0;
    end else if (E) begin
      r_q <= w_nxt;
    end
  end

  assign Q = r_q;

endmodule : reg16_cell

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
//  Module  : register_file
//  Brief   : Eight registers (R1-R4, S1-S4) with two combinational read ports;
//            RF_SAT_EN selects saturating inc/dec in every cell.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file
  import rf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  // Index order matches the read-select encoding: R1..R4 then S1..S4.
  logic [NUM_REG-1:0] w_en;
  logic [WIDTH-1:0]   w_q [NUM_REG];

  assign w_en = {ScrSel, RegSel};

  for (genvar k = 0; k < NUM_REG; k++) begin : g_cell
    reg16_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (w_en[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (w_q[k])
    );
  end

  assign OutA = w_q[OutASel];
  assign OutB = w_q[OutBSel];

endmodule : register_file

`default_nettype wire
